// File: rtl/trace_recorder.sv
// trace_recorder - on-chip trace buffer for the single-cycle CPU.
// Taps the PC and the register-file write port, records one entry per
// qualifying cycle into a DEPTH-entry FIFO during a bounded run, raises
// halt when the run length is reached and streams entries out over a
// first-word-fall-through valid/ready port.
// Optional build macro: TRACE_TIMESTAMP_EN prefixes every entry with the
// CNT_W-bit cycle count of its capture cycle.
module trace_recorder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int CNT_W  = 16,
  parameter int WRAP   = 0,
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = CNT_W + 6 + DATA_W + ADDR_W,
`else
  localparam int ENTRY_W = 6 + DATA_W + ADDR_W,
`endif
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int COUNT_W = PTR_W + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               clear_i,
  input  logic               mode_i,
  input  logic [CNT_W-1:0]   max_cycles_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic               wb_en_i,
  input  logic [4:0]         wb_addr_i,
  input  logic [DATA_W-1:0]  wb_data_i,
  output logic               rd_valid_o,
  input  logic               rd_ready_i,
  output logic [ENTRY_W-1:0] rd_data_o,
  output logic [COUNT_W-1:0] count_o,
  output logic               overflow_o,
  output logic               halt_o,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0]   PTR_ZERO   = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ONE    = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] COUNT_FULL = COUNT_W'(DEPTH);
  localparam bit                 WRAP_EN    = (WRAP != 0);

  state_t               state_r;
  state_t               state_nxt_s;
  logic [CNT_W-1:0]     cycle_cnt_r;
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [COUNT_W-1:0]   count_r;
  logic                 overflow_r;
  logic                 halt_r;
  logic [ENTRY_W-1:0]   mem_r [DEPTH];

  logic [CNT_W-1:0]     last_cnt_s;
  logic                 capture_s;
  logic                 pop_s;
  logic                 full_s;
  logic                 write_s;
  logic                 adv_rd_s;
  logic                 lose_s;
  logic [ENTRY_W-1:0]   entry_s;

  // Run-end cycle, capture/pop qualifiers and the resulting FIFO actions.
  always_comb begin
    last_cnt_s = CNT_ZERO;
    capture_s  = 1'b0;
    pop_s      = 1'b0;
    full_s     = 1'b0;
    write_s    = 1'b0;
    adv_rd_s   = 1'b0;
    lose_s     = 1'b0;
    entry_s    = {ENTRY_W{1'b0}};

    // A programmed length of zero behaves as a one-cycle run.
    if (max_cycles_i == CNT_ZERO) begin
      last_cnt_s = CNT_ZERO;
    end else begin
      last_cnt_s = max_cycles_i - CNT_ONE;
    end

`ifdef TRACE_TIMESTAMP_EN
    entry_s = {cycle_cnt_r, wb_en_i, wb_addr_i, wb_data_i, pc_i};
`else
    entry_s = {wb_en_i, wb_addr_i, wb_data_i, pc_i};
`endif

    capture_s = (state_r == ST_RUN) && !clear_i && (!mode_i || wb_en_i);
    pop_s     = (count_r != COUNT_ZERO) && rd_ready_i && !clear_i;
    full_s    = (count_r == COUNT_FULL);

    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    write_s  = capture_s && (!full_s || pop_s || WRAP_EN);
    // In wrap mode a full push without a pop evicts the oldest entry.
    adv_rd_s = pop_s || (capture_s && full_s && !pop_s && WRAP_EN);
    lose_s   = capture_s && full_s && !pop_s;
  end

  // Next-state logic: clear wins over everything, DONE is left only by clear.
  always_comb begin
    state_nxt_s = state_r;
    if (clear_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (cycle_cnt_r == last_cnt_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DONE: state_nxt_s = ST_DONE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Saturating run cycle counter and the registered halt flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cycle_cnt_r <= CNT_ZERO;
      halt_r      <= 1'b0;
    end else if (clear_i) begin
      cycle_cnt_r <= CNT_ZERO;
      halt_r      <= 1'b0;
    end else begin
      if (state_r == ST_RUN) begin
        if (cycle_cnt_r != CNT_MAX) begin
          cycle_cnt_r <= cycle_cnt_r + CNT_ONE;
        end
      end else if (state_r == ST_IDLE) begin
        cycle_cnt_r <= CNT_ZERO;
      end
      halt_r <= (state_nxt_s == ST_DONE);
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= COUNT_ZERO;
      overflow_r <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= COUNT_ZERO;
      overflow_r <= 1'b0;
    end else begin
      if (write_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (adv_rd_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      if (write_s && !adv_rd_s) begin
        count_r <= count_r + COUNT_ONE;
      end else if (adv_rd_s && !write_s) begin
        count_r <= count_r - COUNT_ONE;
      end
      if (lose_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Trace storage; contents are don't-care after reset, so it has no reset.
  always_ff @(posedge clk_i) begin
    if (write_s) begin
      mem_r[wr_ptr_r] <= entry_s;
    end
  end

  assign rd_data_o  = mem_r[rd_ptr_r];
  assign rd_valid_o = (count_r != COUNT_ZERO);
  assign count_o    = count_r;
  assign overflow_o = overflow_r;
  assign halt_o     = halt_r;
  assign state_o    = state_r;

endmodule

// File: tb/tb_trace_recorder.sv
// tb_trace_recorder - randomized self-checking bench for trace_recorder.
// Three instances share all inputs: DEPTH=64/WRAP=0, DEPTH=4/WRAP=0 and
// DEPTH=4/WRAP=1. A queue-level model predicts every output each cycle.
`timescale 1ns/1ps
module tb_trace_recorder;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
`ifdef TRACE_TIMESTAMP_EN
  localparam int EW = CNT_W + 6 + DATA_W + ADDR_W;
`else
  localparam int EW = 6 + DATA_W + ADDR_W;
`endif
  localparam int NI = 3;

  logic              clk;
  logic              rst_i;
  logic              start;
  logic              clear;
  logic              mode;
  logic [CNT_W-1:0]  max_cycles;
  logic [ADDR_W-1:0] pc;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              rd_ready;

  logic          v0, v1, v2, o0, o1, o2, h0, h1, h2;
  logic [EW-1:0] d0, d1, d2;
  logic [6:0]    c0;
  logic [2:0]    c1, c2;
  logic [1:0]    s0, s1, s2;

  trace_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(64), .CNT_W(CNT_W), .WRAP(0)) dut0 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start), .clear_i(clear), .mode_i(mode),
    .max_cycles_i(max_cycles), .pc_i(pc), .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .rd_valid_o(v0), .rd_ready_i(rd_ready), .rd_data_o(d0),
    .count_o(c0), .overflow_o(o0), .halt_o(h0), .state_o(s0));

  trace_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4), .CNT_W(CNT_W), .WRAP(0)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start), .clear_i(clear), .mode_i(mode),
    .max_cycles_i(max_cycles), .pc_i(pc), .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .rd_valid_o(v1), .rd_ready_i(rd_ready), .rd_data_o(d1),
    .count_o(c1), .overflow_o(o1), .halt_o(h1), .state_o(s1));

  trace_recorder #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(4), .CNT_W(CNT_W), .WRAP(1)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start), .clear_i(clear), .mode_i(mode),
    .max_cycles_i(max_cycles), .pc_i(pc), .wb_en_i(wb_en), .wb_addr_i(wb_addr),
    .wb_data_i(wb_data), .rd_valid_o(v2), .rd_ready_i(rd_ready), .rd_data_o(d2),
    .count_o(c2), .overflow_o(o2), .halt_o(h2), .state_o(s2));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model: run phase, cycle index, and one ordered list per instance.
  int            m_state;
  int            m_cyc;
  bit            m_halt;
  bit            m_ovf  [NI];
  int            m_len  [NI];
  logic [EW-1:0] m_list [NI][64];

  function automatic int dep_of(input int k);
    return (k == 0) ? 64 : 4;
  endfunction

  function automatic bit wrap_of(input int k);
    return (k == 2);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cyc   = 0;
    m_halt  = 1'b0;
    for (int k = 0; k < NI; k++) begin
      m_ovf[k] = 1'b0;
      m_len[k] = 0;
    end
  endtask

  task automatic shift_out(input int k);
    for (int i = 0; i < 63; i++) m_list[k][i] = m_list[k][i+1];
    m_len[k] = m_len[k] - 1;
  endtask

  task automatic append(input int k, input logic [EW-1:0] e);
    m_list[k][m_len[k]] = e;
    m_len[k] = m_len[k] + 1;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_step();
    logic [EW-1:0]    e;
    logic [CNT_W-1:0] ts;
    bit               push;
    int               lastc;
    if (!rst_i || clear) begin
      model_reset();
      return;
    end
    ts = m_cyc[CNT_W-1:0];
`ifdef TRACE_TIMESTAMP_EN
    e = {ts, wb_en, wb_addr, wb_data, pc};
`else
    e = {wb_en, wb_addr, wb_data, pc};
`endif
    push = (m_state == 1) && (!mode || wb_en);
    for (int k = 0; k < NI; k++) begin
      if (m_len[k] > 0 && rd_ready) shift_out(k);
      if (push) begin
        if (m_len[k] < dep_of(k)) begin
          append(k, e);
        end else begin
          m_ovf[k] = 1'b1;
          if (wrap_of(k)) begin
            shift_out(k);
            append(k, e);
          end
        end
      end
    end
    if (m_state == 0) begin
      if (start) begin
        m_state = 1;
        m_cyc   = 0;
      end
    end else if (m_state == 1) begin
      lastc = (max_cycles == 0) ? 0 : int'(max_cycles) - 1;
      if (m_cyc == lastc) begin
        m_state = 2;
        m_halt  = 1'b1;
      end
      if (m_cyc < (1 << CNT_W) - 1) m_cyc = m_cyc + 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic compare_inst(input int k);
    logic [127:0]  ac;
    logic          av, ao, ah;
    logic [1:0]    ast;
    logic [EW-1:0] ad;
    case (k)
      0:       begin ac = 128'(c0); av = v0; ao = o0; ah = h0; ast = s0; ad = d0; end
      1:       begin ac = 128'(c1); av = v1; ao = o1; ah = h1; ast = s1; ad = d1; end
      default: begin ac = 128'(c2); av = v2; ao = o2; ah = h2; ast = s2; ad = d2; end
    endcase
    chk($sformatf("i%0d count", k), ac, 128'(m_len[k]));
    chk($sformatf("i%0d valid", k), 128'(av), 128'(m_len[k] > 0));
    chk($sformatf("i%0d overflow", k), 128'(ao), 128'(m_ovf[k]));
    chk($sformatf("i%0d halt", k), 128'(ah), 128'(m_halt));
    chk($sformatf("i%0d state", k), 128'(ast), 128'(m_state));
    if (m_len[k] > 0) chk($sformatf("i%0d data", k), 128'(ad), 128'(m_list[k][0]));
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare process: every falling edge, all instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int k = 0; k < NI; k++) compare_inst(k);
      end
    end
  end

  initial begin
    logic [EW-1:0] exp_e;
    rst_i = 1'b0; start = 1'b0; clear = 1'b0; mode = 1'b0; max_cycles = '0;
    pc = '0; wb_en = 1'b0; wb_addr = '0; wb_data = '0; rd_ready = 1'b0;
    model_reset();
    tick();
    tick();
    rst_i  = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset count", 128'(c0), 128'd0);
    chk("reset valid", 128'(v0), 128'd0);
    chk("reset state", 128'(s0), 128'd0);
    chk("reset halt", 128'(h0), 128'd0);

    // Run of 30 cycles capturing every cycle, PC stepping by 4, no reads.
    start = 1'b1; mode = 1'b0; max_cycles = 16'd30;
    tick();
    start = 1'b0;
    for (int c = 0; c < 35; c++) begin
      pc = 32'(4 * c); wb_en = 1'($urandom); wb_addr = 5'($urandom); wb_data = $urandom;
      tick();
    end
    @(negedge clk);
    chk("run30 halt", 128'(h0), 128'd1);
    chk("run30 count", 128'(c0), 128'd30);
    chk("run30 overflow", 128'(o0), 128'd0);
    chk("drop count", 128'(c1), 128'd4);
    chk("drop overflow", 128'(o1), 128'd1);
    chk("drop head pc", 128'(d1[ADDR_W-1:0]), 128'd0);
    chk("wrap count", 128'(c2), 128'd4);
    chk("wrap overflow", 128'(o2), 128'd1);
    chk("wrap head pc", 128'(d2[ADDR_W-1:0]), 128'd104);
    tick();
    rd_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("drain pc", 128'(d0[ADDR_W-1:0]), 128'(4 * i));
      tick();
    end
    @(negedge clk);
    chk("drained count", 128'(c0), 128'd0);
    chk("drained valid", 128'(v0), 128'd0);

    // Clear in DONE, with start held high to show it is ignored.
    clear = 1'b1; start = 1'b1;
    tick();
    clear = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("clear state", 128'(s0), 128'd0);
    chk("clear halt", 128'(h0), 128'd0);
    chk("clear count", 128'(c0), 128'd0);

    // Sparse capture: write-back only on run cycles 2 and 7.
    rd_ready = 1'b0; mode = 1'b1; max_cycles = 16'd10; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      wb_en = (c == 2 || c == 7); wb_addr = 5'd8;
      wb_data = (c == 2) ? 32'd5 : ((c == 7) ? 32'd9 : 32'(c));
      pc = 32'h1000 + 32'(4 * c);
      tick();
    end
    @(negedge clk);
    chk("sparse count", 128'(c0), 128'd2);
    chk("sparse halt", 128'(h0), 128'd1);
`ifdef TRACE_TIMESTAMP_EN
    exp_e = {16'd2, 1'b1, 5'd8, 32'd5, 32'h0000_1008};
`else
    exp_e = {1'b1, 5'd8, 32'd5, 32'h0000_1008};
`endif
    chk("sparse entry0", 128'(d0), 128'(exp_e));
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    @(negedge clk);
`ifdef TRACE_TIMESTAMP_EN
    exp_e = {16'd7, 1'b1, 5'd8, 32'd9, 32'h0000_101C};
`else
    exp_e = {1'b1, 5'd8, 32'd9, 32'h0000_101C};
`endif
    chk("sparse entry1", 128'(d0), 128'(exp_e));
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Full DEPTH=4 FIFO with a reader draining every cycle during capture.
    mode = 1'b0; max_cycles = 16'd20; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      rd_ready = (c >= 4); pc = 32'(4 * c); wb_en = 1'($urandom); wb_data = $urandom;
      @(negedge clk);
      if (c == 10) begin
        chk("steady count", 128'(c1), 128'd4);
        chk("steady overflow", 128'(o1), 128'd0);
        chk("steady wrap overflow", 128'(o2), 128'd0);
        chk("steady head pc", 128'(d1[ADDR_W-1:0]), 128'd24);
      end
      tick();
    end
    clear = 1'b1; rd_ready = 1'b0;
    tick();
    clear = 1'b0;

    // Asynchronous reset in the middle of a run.
    max_cycles = 16'd30; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      pc = 32'(4 * c);
      tick();
    end
    rst_i = 1'b0;
    model_reset();
    #1;
    chk("async count", 128'(c0), 128'd0);
    chk("async valid", 128'(v0), 128'd0);
    chk("async state", 128'(s0), 128'd0);
    chk("async overflow", 128'(o1), 128'd0);
    chk("async halt", 128'(h0), 128'd0);
    tick();
    rst_i = 1'b1;
    tick();

    // Randomized traffic: starts, clears, resets, mode and length changes.
    begin
      int rdp;
      rdp = 50;
      for (int n = 0; n < 2500; n++) begin
        if (n % 64 == 0) begin
          mode = 1'($urandom);
          max_cycles = 16'($urandom_range(0, 100));
        end
        if (n % 128 == 0) rdp = $urandom_range(0, 100);
        clear    = ($urandom_range(0, 59) == 0);
        start    = ($urandom_range(0, 3) == 0);
        wb_en    = 1'($urandom);
        wb_addr  = 5'($urandom);
        wb_data  = $urandom;
        pc       = $urandom;
        rd_ready = ($urandom_range(0, 99) < rdp);
        if (!rst_i) begin
          rst_i = 1'b1;
        end else if ($urandom_range(0, 399) == 0) begin
          rst_i = 1'b0;
          model_reset();
        end
        tick();
      end
    end
    rst_i = 1'b1; clear = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
